// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
//   DIGITS / BCD_W : display geometry (6 packed-BCD digits, 24 bits)
//   GLYPH_*        : active-high {g,f,e,d,c,b,a} segment patterns
package seg7_pkg;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned BCD_W  = 24;

  localparam logic [6:0] GLYPH_0   = 7'h3F;
  localparam logic [6:0] GLYPH_1   = 7'h06;
  localparam logic [6:0] GLYPH_2   = 7'h5B;
  localparam logic [6:0] GLYPH_3   = 7'h4F;
  localparam logic [6:0] GLYPH_4   = 7'h66;
  localparam logic [6:0] GLYPH_5   = 7'h6D;
  localparam logic [6:0] GLYPH_6   = 7'h7D;
  localparam logic [6:0] GLYPH_7   = 7'h07;
  localparam logic [6:0] GLYPH_8   = 7'h7F;
  localparam logic [6:0] GLYPH_9   = 7'h6F;
  localparam logic [6:0] GLYPH_E   = 7'h79;
  localparam logic [6:0] GLYPH_OFF = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder.
//   nibble  : BCD digit; A..F decode to an 'E' error glyph
//   blank   : force all segments (including dp) off
//   dp      : decimal point request
//   pattern : active-high {dp,g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [6:0] glyph;

  always_comb begin
    glyph = GLYPH_E;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      default: glyph = GLYPH_E;
    endcase
  end

  always_comb begin
    pattern = {dp, glyph};
    if (blank) begin
      pattern = {1'b0, GLYPH_OFF};
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit 7-segment display driver.
//   clk, rst   : clock, synchronous active-high reset
//   data_in    : packed BCD word, digit 5 in [23:20]
//   data_valid : one-cycle strobe, captures data_in as a pending update
//   blank_lz   : blank leading zeros (digit 0 always shown)
//   dp_mask    : per-digit decimal point enable (live, not shadowed)
//   sel        : one-hot digit select, polarity per ACT_LOW
//   seg        : {dp,g,f,e,d,c,b,a}, polarity per ACT_LOW
//   frame_done : one-cycle pulse when the digit 5 dwell ends
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned BLANK_CYC = 500,
  parameter bit          ACT_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BCD_W-1:0]  data_in,
  input  logic              data_valid,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic              frame_done
);

  localparam int unsigned       TickW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [2:0]        LastIdx = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SelOff  = ACT_LOW ? '1 : '0;
  localparam logic [7:0]        SegOff  = ACT_LOW ? 8'hFF : 8'h00;

  logic [TickW-1:0]  tick_q, tick_d;
  logic [2:0]        idx_q, idx_d;
  logic [BCD_W-1:0]  pending_q, pending_d;
  logic              pending_vld_q, pending_vld_d;
  logic [BCD_W-1:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic              tick_wrap;
  logic              frame_end;
  logic              blank_phase;
  logic              digit_blank;
  logic [3:0]        digits [DIGITS];
  logic [DIGITS-1:0] zero_above;
  logic [DIGITS-1:0] sel_hot;
  logic [7:0]        pattern;

  assign tick_wrap   = (32'(tick_q) == SCAN_DIV - 1);
  assign frame_end   = tick_wrap && (idx_q == LastIdx);
  assign blank_phase = (32'(tick_q) < BLANK_CYC);

  // Scan counters
  always_comb begin
    tick_d = tick_q + 1'b1;
    idx_d  = idx_q;
    if (tick_wrap) begin
      tick_d = '0;
      idx_d  = (idx_q == LastIdx) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Pending/shadow: the shadow only changes at the frame boundary so a frame never tears.
  // A strobe landing exactly on the boundary bypasses the pending register.
  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    shadow_d      = shadow_q;
    if (data_valid) begin
      pending_d     = data_in;
      pending_vld_d = 1'b1;
    end
    if (frame_end) begin
      if (data_valid) begin
        shadow_d = data_in;
      end else if (pending_vld_q) begin
        shadow_d = pending_q;
      end
      pending_vld_d = 1'b0;
    end
  end

  // zero_above[i]: shadow digits DIGITS-1 down to i are all zero
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digits[i] = shadow_q[4*i +: 4];
    end
    zero_above = '0;
    zero_above[DIGITS-1] = (digits[DIGITS-1] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (digits[i] == 4'h0);
    end
  end

  assign digit_blank = blank_lz && (idx_q != 3'd0) && zero_above[idx_q];

  seg7_decode u_decode (
    .nibble  (digits[idx_q]),
    .blank   (digit_blank || blank_phase),
    .dp      (dp_mask[idx_q]),
    .pattern (pattern)
  );

  always_comb begin
    sel_hot        = '0;
    sel_hot[idx_q] = 1'b1;
    sel_d          = ACT_LOW ? ~sel_hot : sel_hot;
    seg_d          = ACT_LOW ? ~pattern : pattern;
    if (blank_phase) begin
      sel_d = SelOff;
      seg_d = SegOff;
    end
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q        <= '0;
      idx_q         <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      shadow_q      <= '0;
      sel_q         <= SelOff;
      seg_q         <= SegOff;
      frame_done_q  <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      shadow_q      <= shadow_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data_in;
  logic        data_valid;
  logic        blank_lz;
  logic [5:0]  dp_mask;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0] got_seg  [6];
  logic [5:0] got_sel  [6];
  logic [5:0] got_bsel [6];

  seg7_scan_driver #(
    .SCAN_DIV  (4),
    .BLANK_CYC (1),
    .ACT_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until frame_done is seen (at least one step); bounded.
  task automatic wait_fd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_wait", 32'(seen), 32'd1);
  endtask

  // Called in the frame_done cycle; records the following frame and ends on its frame_done.
  task automatic capture();
    for (int d = 0; d < 6; d++) begin
      step();
      got_bsel[d] = sel;
      step();
      got_sel[d] = sel;
      got_seg[d] = seg;
      step();
      step();
    end
  endtask

  task automatic strobe(input logic [23:0] v);
    data_in    = v;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    blank_lz   = 1'b0;
    dp_mask    = '0;

    // 1 Reset
    repeat (3) step();
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    step();
    check("first_blank_sel", 32'(sel), 32'h3F);
    step();
    check("first_d0_sel", 32'(sel), 32'h3E);
    check("first_d0_seg", 32'(seg), 32'hC0);

    // 2 Update deferred to the frame boundary
    strobe(24'h123456);
    check("no_tear_seg", 32'(seg), 32'hC0);
    wait_fd();
    step();
    check("fd_pulse_width", 32'(frame_done), 32'h0);
    wait_fd();
    capture();
    check("upd_d0", 32'(got_seg[0]), 32'h82);
    check("upd_d1", 32'(got_seg[1]), 32'h92);
    check("upd_d3", 32'(got_seg[3]), 32'hB0);
    check("upd_d5", 32'(got_seg[5]), 32'hF9);
    check("sel_d0", 32'(got_sel[0]), 32'h3E);
    check("sel_d1", 32'(got_sel[1]), 32'h3D);
    check("sel_d2", 32'(got_sel[2]), 32'h3B);
    check("sel_d3", 32'(got_sel[3]), 32'h37);
    check("sel_d4", 32'(got_sel[4]), 32'h2F);
    check("sel_d5", 32'(got_sel[5]), 32'h1F);
    check("blank_sel_d3", 32'(got_bsel[3]), 32'h3F);
    check("capture_end_fd", 32'(frame_done), 32'h1);

    // 3 Last wins, then a strobe on the boundary cycle itself
    strobe(24'h000111);
    step();
    strobe(24'h000222);
    wait_fd();
    capture();
    check("last_d0", 32'(got_seg[0]), 32'hA4);
    check("last_d2", 32'(got_seg[2]), 32'hA4);
    check("last_d3", 32'(got_seg[3]), 32'hC0);
    repeat (23) step();
    strobe(24'h999999);
    check("bypass_fd", 32'(frame_done), 32'h1);
    capture();
    check("bypass_d0", 32'(got_seg[0]), 32'h90);
    check("bypass_d5", 32'(got_seg[5]), 32'h90);

    // 4 Leading-zero blanking
    blank_lz = 1'b1;
    strobe(24'h000105);
    wait_fd();
    capture();
    check("lz_d0", 32'(got_seg[0]), 32'h92);
    check("lz_d1", 32'(got_seg[1]), 32'hC0);
    check("lz_d2", 32'(got_seg[2]), 32'hF9);
    check("lz_d3", 32'(got_seg[3]), 32'hFF);
    check("lz_d5", 32'(got_seg[5]), 32'hFF);
    check("lz_d5_sel", 32'(got_sel[5]), 32'h1F);
    strobe(24'h000000);
    wait_fd();
    capture();
    check("zero_d0", 32'(got_seg[0]), 32'hC0);
    check("zero_d1", 32'(got_seg[1]), 32'hFF);
    blank_lz = 1'b0;
    capture();
    check("nolz_d1", 32'(got_seg[1]), 32'hC0);
    check("nolz_d5", 32'(got_seg[5]), 32'hC0);

    // 5 Error glyph and decimal point
    blank_lz = 1'b1;
    dp_mask  = 6'b000100;
    strobe(24'h00A000);
    wait_fd();
    capture();
    check("err_d3", 32'(got_seg[3]), 32'h86);
    check("dp_d2", 32'(got_seg[2]), 32'h40);
    check("err_d1", 32'(got_seg[1]), 32'hC0);
    check("err_d4", 32'(got_seg[4]), 32'hFF);
    check("err_d5", 32'(got_seg[5]), 32'hFF);

    // 6 Reset during digit 3 with an update pending
    blank_lz = 1'b0;
    dp_mask  = '0;
    strobe(24'h000777);
    repeat (13) step();
    check("pre_rst_sel", 32'(sel), 32'h37);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_sel", 32'(sel), 32'h3F);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    step();
    check("post_rst_blank", 32'(sel), 32'h3F);
    step();
    check("post_rst_d0_sel", 32'(sel), 32'h3E);
    check("post_rst_d0_seg", 32'(seg), 32'hC0);
    wait_fd();
    capture();
    check("lost_d0", 32'(got_seg[0]), 32'hC0);
    check("lost_d2", 32'(got_seg[2]), 32'hC0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
